mc_ctrl_fsm: RTL

- Multicycle control FSM for the MIPS core.
- Sequences one instruction over 3-5 cycles through a shared ALU and unified instruction/data memory.
- Consumes op, funct and zero from the datapath. Produces per-cycle mux selects, write enables and a 4-bit aluop for the existing aludec.
- Stalls on a memory ready handshake so slow memories can be attached.

---
 rtl/mc_ctrl_pkg.sv | 84 ++++++++
 rtl/mc_ctrl_outdec.sv | 107 ++++++++++
 rtl/mc_ctrl_fsm.sv | 90 +++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// The control word struct is the interface between the output decoder and the FSM top.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      IEXEC   = 4'd9,
      IWB     = 4'd10,
      JUMP    = 4'd11,
      JR      = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_LB   = 6'b100000;
   localparam logic [5:0] OP_LBU  = 6'b100100;
   localparam logic [5:0] OP_SB   = 6'b101000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   localparam logic [5:0] FUNCT_JR = 6'b001000;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_FUNCT = 4'b0010;
   localparam logic [3:0] ALU_AND   = 4'b0011;
   localparam logic [3:0] ALU_OR    = 4'b0100;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_JR     = 2'b11;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       ne;
      logic       iord;
      logic       irwrite;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       link;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       zext;
      logic [1:0] pcsrc;
      logic [3:0] aluop;
      logic       lbu;
      logic       bytesel;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_SB);
   endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of the current state and opcode into the control word.
// Only FETCH and MEMWR look at mem_ready, so a stalled access never commits.
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   logic legal_op;

   assign legal_op = is_load(op) || is_store(op) || (op == OP_R) ||
                     (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI) ||
                     (op == OP_ANDI) || (op == OP_ORI) || (op == OP_J) ||
                     (op == OP_JAL);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.memread = 1'b1;
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         DECODE: begin
            ctrl.alusrcb = SRCB_IMM_SH;
            ctrl.illegal = !legal_op;
         end
         MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         MEMRD: begin
            ctrl.iord    = 1'b1;
            ctrl.memread = 1'b1;
            ctrl.bytesel = (op == OP_LB) || (op == OP_LBU);
            ctrl.lbu     = (op == OP_LBU);
         end
         MEMWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.memtoreg   = 1'b1;
            ctrl.bytesel    = (op == OP_LB) || (op == OP_LBU);
            ctrl.lbu        = (op == OP_LBU);
            ctrl.instr_done = 1'b1;
         end
         MEMWR: begin
            ctrl.iord       = 1'b1;
            ctrl.memwrite   = 1'b1;
            ctrl.bytesel    = (op == OP_SB);
            ctrl.instr_done = mem_ready;
         end
         EXECUTE: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.aluop   = ALU_FUNCT;
         end
         ALUWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.regdst     = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         BRANCH: begin
            ctrl.alusrca    = 1'b1;
            ctrl.alusrcb    = SRCB_B;
            ctrl.aluop      = ALU_SUB;
            ctrl.pcsrc      = PC_ALUOUT;
            ctrl.branch     = 1'b1;
            ctrl.ne         = (op == OP_BNE);
            ctrl.instr_done = 1'b1;
         end
         IEXEC: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            if (op == OP_ANDI) begin
               ctrl.aluop = ALU_AND;
               ctrl.zext  = 1'b1;
            end else if (op == OP_ORI) begin
               ctrl.aluop = ALU_OR;
               ctrl.zext  = 1'b1;
            end
         end
         IWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.zext       = (op == OP_ANDI) || (op == OP_ORI);
            ctrl.instr_done = 1'b1;
         end
         JUMP: begin
            // PC was already advanced in FETCH, so it is the link value for jal
            ctrl.pcsrc      = PC_JUMP;
            ctrl.pcwrite    = 1'b1;
            ctrl.regwrite   = (op == OP_JAL);
            ctrl.link       = (op == OP_JAL);
            ctrl.instr_done = 1'b1;
         end
         JR: begin
            ctrl.pcsrc      = PC_JR;
            ctrl.pcwrite    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: state register, next-state logic and pcen gate.
// Outputs come straight from the decoder, so an async clear shows FETCH values at once.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned RA_REG = 31
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       iord,
   output logic       irwrite,
   output logic       memread,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       link,
   output logic [4:0] link_reg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       zext,
   output logic [1:0] pcsrc,
   output logic [3:0] aluop,
   output logic       lbu,
   output logic       bytesel,
   output logic       instr_done,
   output logic       illegal
);

   state_t state_reg;
   ctrl_t  ctrl;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= FETCH;
      end else begin
         case (state_reg)
            FETCH:   if (mem_ready) state_reg <= DECODE;
            DECODE: begin
               if (is_load(op) || is_store(op))               state_reg <= MEMADR;
               else if (op == OP_R)                           state_reg <= (funct == FUNCT_JR) ? JR : EXECUTE;
               else if ((op == OP_BEQ) || (op == OP_BNE))     state_reg <= BRANCH;
               else if ((op == OP_ADDI) || (op == OP_ANDI) ||
                        (op == OP_ORI))                       state_reg <= IEXEC;
               else if ((op == OP_J) || (op == OP_JAL))       state_reg <= JUMP;
               else                                           state_reg <= FETCH;
            end
            MEMADR:  state_reg <= is_load(op) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_reg <= MEMWB;
            MEMWR:   if (mem_ready) state_reg <= FETCH;
            EXECUTE: state_reg <= ALUWB;
            IEXEC:   state_reg <= IWB;
            default: state_reg <= FETCH;
         endcase
      end
   end

   mc_ctrl_outdec u_outdec (
      .state     (state_reg),
      .op        (op),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign pcen       = ctrl.pcwrite | (ctrl.branch & (zero ^ ctrl.ne));
   assign iord       = ctrl.iord;
   assign irwrite    = ctrl.irwrite;
   assign memread    = ctrl.memread;
   assign memwrite   = ctrl.memwrite;
   assign memtoreg   = ctrl.memtoreg;
   assign regdst     = ctrl.regdst;
   assign regwrite   = ctrl.regwrite;
   assign link       = ctrl.link;
   assign link_reg   = 5'(RA_REG);
   assign alusrca    = ctrl.alusrca;
   assign alusrcb    = ctrl.alusrcb;
   assign zext       = ctrl.zext;
   assign pcsrc      = ctrl.pcsrc;
   assign aluop      = ctrl.aluop;
   assign lbu        = ctrl.lbu;
   assign bytesel    = ctrl.bytesel;
   assign instr_done = ctrl.instr_done;
   assign illegal    = ctrl.illegal;

endmodule
